// File: rtl/memtrace_replay_queue.sv
// memtrace_replay_queue: cycle-stamped multi-lane memory-trace replay FIFO
// Ports: clock, reset_n (async active-low); in_* push one trace entry per
// in_valid & in_ready; out_* present the head entry on every lane in its mask
// once its stamp is due, each lane with its own ready/valid; cycle is trace
// time, stall_cycles counts due-but-blocked cycles, finished flags replay done.
module memtrace_replay_queue #(
  parameter int NUM_LANES   = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int SIZE_WIDTH  = 32,
  parameter int CYCLE_WIDTH = 64,
  parameter int STALL_TIME  = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CYCLE_WIDTH-1:0]           in_cycle,
  input  logic [NUM_LANES-1:0]             in_lane_mask,
  input  logic [ADDR_WIDTH*NUM_LANES-1:0]  in_address,
  input  logic [NUM_LANES-1:0]             in_is_store,
  input  logic [SIZE_WIDTH*NUM_LANES-1:0]  in_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  in_data,
  input  logic                             in_finished,
  output logic [NUM_LANES-1:0]             out_valid,
  input  logic [NUM_LANES-1:0]             out_ready,
  output logic [ADDR_WIDTH*NUM_LANES-1:0]  out_address,
  output logic [NUM_LANES-1:0]             out_is_store,
  output logic [SIZE_WIDTH*NUM_LANES-1:0]  out_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]  out_data,
  output logic [CYCLE_WIDTH-1:0]           cycle,
  output logic [31:0]                      stall_cycles,
  output logic                             finished
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [CYCLE_WIDTH-1:0]          cyc_mem  [DEPTH];
  logic [NUM_LANES-1:0]            mask_mem [DEPTH];
  logic [ADDR_WIDTH*NUM_LANES-1:0] addr_mem [DEPTH];
  logic [NUM_LANES-1:0]            st_mem   [DEPTH];
  logic [SIZE_WIDTH*NUM_LANES-1:0] size_mem [DEPTH];
  logic [DATA_WIDTH*NUM_LANES-1:0] data_mem [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [NUM_LANES-1:0]   served_q, served_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic [31:0]            stall_q, stall_d;
  logic                   fin_seen_q, fin_seen_d, finished_q, finished_d;
  logic                   enq, head_due, retire;
  logic [NUM_LANES-1:0]   pend;
  // The head retires once every lane still pending is accepted this cycle;
  // a zero mask therefore retires on its first due cycle.
  always_comb begin
    head_due   = (count_q != '0) && (cyc_mem[rd_ptr_q] <= cycle_q);
    pend       = mask_mem[rd_ptr_q] & ~served_q;
    out_valid  = head_due ? pend : '0;
    retire     = head_due && ((pend & ~out_ready) == '0);
    in_ready   = reset_n && (count_q != CW'(DEPTH)) && !fin_seen_q;
    enq        = in_valid && in_ready;
    wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = retire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(enq) - CW'(retire);
    served_d   = retire ? '0 : served_q | (out_valid & out_ready);
    cycle_d    = (STALL_TIME != 0 && head_due && !retire) ? cycle_q : cycle_q + CYCLE_WIDTH'(1);
    stall_d    = (head_due && !retire && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    fin_seen_d = fin_seen_q || in_finished;
    finished_d = finished_q || (fin_seen_d && count_d == '0);
  end
  always_ff @(posedge clock) begin
    if (enq) begin
      cyc_mem[wr_ptr_q]  <= in_cycle;
      mask_mem[wr_ptr_q] <= in_lane_mask;
      addr_mem[wr_ptr_q] <= in_address;
      st_mem[wr_ptr_q]   <= in_is_store;
      size_mem[wr_ptr_q] <= in_size;
      data_mem[wr_ptr_q] <= in_data;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      served_q   <= '0;
      cycle_q    <= '0;
      stall_q    <= '0;
      fin_seen_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      served_q   <= served_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      fin_seen_q <= fin_seen_d;
      finished_q <= finished_d;
    end
  end
  assign out_address  = addr_mem[rd_ptr_q];
  assign out_is_store = st_mem[rd_ptr_q];
  assign out_size     = size_mem[rd_ptr_q];
  assign out_data     = data_mem[rd_ptr_q];
  assign cycle        = cycle_q;
  assign stall_cycles = stall_q;
  assign finished     = finished_q;
endmodule

// File: tb/tb_memtrace_replay_queue.sv
// tb_memtrace_replay_queue: two instances (STALL_TIME 0 and 1) against a queue-based reference model
module tb_memtrace_replay_queue;
  typedef struct {
    logic [63:0]  cyc;
    logic [3:0]   mask;
    logic [255:0] addr;
    logic [3:0]   st;
    logic [127:0] size;
    logic [255:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_finished;
  logic [63:0] in_cycle;
  logic [3:0] in_lane_mask, in_is_store, out_ready;
  logic [255:0] in_address, in_data;
  logic [127:0] in_size;
  logic rdy [2];
  logic [3:0] ov [2];
  logic [255:0] oaddr [2];
  logic [3:0] ost [2];
  logic [127:0] osize [2];
  logic [255:0] odata [2];
  logic [63:0] ocyc [2];
  logic [31:0] ostall [2];
  logic ofin [2];
  ent_t q0[$], q1[$];
  logic [3:0] m_served [2];
  logic [63:0] m_cyc [2];
  logic [31:0] m_stall [2];
  bit m_fs [2], m_fin [2];
  int acc0, errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    memtrace_replay_queue #(.STALL_TIME(i)) u_dut (
      .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[i]),
      .in_cycle(in_cycle), .in_lane_mask(in_lane_mask), .in_address(in_address),
      .in_is_store(in_is_store), .in_size(in_size), .in_data(in_data),
      .in_finished(in_finished), .out_valid(ov[i]), .out_ready(out_ready),
      .out_address(oaddr[i]), .out_is_store(ost[i]), .out_size(osize[i]),
      .out_data(odata[i]), .cycle(ocyc[i]), .stall_cycles(ostall[i]), .finished(ofin[i]));
  end

  function automatic int qsize(int k);
    return k != 0 ? q1.size() : q0.size();
  endfunction
  function automatic ent_t qhead(int k);
    return k != 0 ? q1[0] : q0[0];
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [255:0] lanes64(logic [3:0] m);
    logic [255:0] r;
    for (int g = 0; g < 4; g++) r[64*g +: 64] = {64{m[g]}};
    return r;
  endfunction
  function automatic logic [127:0] lanes32(logic [3:0] m);
    logic [127:0] r;
    for (int g = 0; g < 4; g++) r[32*g +: 32] = {32{m[g]}};
    return r;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_served[k] = '0;
      m_cyc[k] = '0;
      m_stall[k] = '0;
      m_fs[k] = 1'b0;
      m_fin[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      ent_t h;
      bit due;
      logic [3:0] ev;
      due = 1'b0;
      ev = '0;
      if (qsize(k) != 0) begin
        h = qhead(k);
        due = h.cyc <= m_cyc[k];
        ev = due ? (h.mask & ~m_served[k]) : 4'h0;
      end
      chk($sformatf("in_ready[%0d]", k), rdy[k], (qsize(k) < 8) && !m_fs[k]);
      chk($sformatf("out_valid[%0d]", k), ov[k], ev);
      chk($sformatf("cycle[%0d]", k), ocyc[k], m_cyc[k]);
      chk($sformatf("stall_cycles[%0d]", k), ostall[k], m_stall[k]);
      chk($sformatf("finished[%0d]", k), ofin[k], m_fin[k]);
      if (ev != 0) begin
        chk($sformatf("out_address[%0d]", k), oaddr[k] & lanes64(ev), h.addr & lanes64(ev));
        chk($sformatf("out_data[%0d]", k), odata[k] & lanes64(ev), h.data & lanes64(ev));
        chk($sformatf("out_size[%0d]", k), osize[k] & lanes32(ev), h.size & lanes32(ev));
        chk($sformatf("out_is_store[%0d]", k), ost[k] & ev, h.st & ev);
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      ent_t h, e;
      bit due, ret, acc;
      logic [3:0] rem;
      due = 1'b0;
      rem = '0;
      if (qsize(k) != 0) begin
        h = qhead(k);
        due = h.cyc <= m_cyc[k];
        rem = h.mask & ~m_served[k];
      end
      ret = due && ((rem & ~out_ready) == 4'h0);
      acc = in_valid && (qsize(k) < 8) && !m_fs[k];
      if (ret) begin
        if (k != 0) void'(q1.pop_front()); else void'(q0.pop_front());
        m_served[k] = '0;
      end else if (due) m_served[k] = m_served[k] | (rem & out_ready);
      if (acc) begin
        e = '{in_cycle, in_lane_mask, in_address, in_is_store, in_size, in_data};
        if (k != 0) q1.push_back(e); else begin q0.push_back(e); acc0++; end
      end
      if (!(k == 1 && due && !ret)) m_cyc[k] = m_cyc[k] + 64'd1;
      if (due && !ret && m_stall[k] != 32'hffff_ffff) m_stall[k] = m_stall[k] + 32'd1;
      m_fs[k] = m_fs[k] || in_finished;
      m_fin[k] = m_fin[k] || (m_fs[k] && qsize(k) == 0);
    end
  endtask

  task automatic cyc_step();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drv(bit v, logic [63:0] c, logic [3:0] m, logic [3:0] r, bit f);
    logic [255:0] t;
    in_valid = v;
    in_cycle = c;
    in_lane_mask = m;
    out_ready = r;
    in_finished = f;
    in_address = rnd256();
    in_data = rnd256();
    t = rnd256();
    in_size = t[127:0];
    in_is_store = 4'($urandom);
  endtask

  // Asserts reset between edges and checks the outputs respond without a clock.
  task automatic do_reset();
    drv(0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), ov[k], 4'h0);
      chk($sformatf("rst_in_ready[%0d]", k), rdy[k], 1'b0);
      chk($sformatf("rst_cycle[%0d]", k), ocyc[k], 64'd0);
      chk($sformatf("rst_stall[%0d]", k), ostall[k], 32'd0);
      chk($sformatf("rst_finished[%0d]", k), ofin[k], 1'b0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    drv(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();
    // timed release at stamp 5
    drv(1, 5, 4'b0011, 4'hf, 0);
    in_address = '0;
    in_address[63:0] = 64'h1000;
    in_address[127:64] = 64'h2000;
    cyc_step();
    drv(0, 0, 0, 4'hf, 0);
    repeat (4) cyc_step();
    #1 chk("release_valid", ov[0], 4'b0011);
    chk("release_addr", oaddr[0][127:0], {64'h2000, 64'h1000});
    chk("release_cycle", ocyc[0], 64'd5);
    cyc_step();
    #1 chk("release_done", ov[0], 4'h0);
    chk("release_done_cycle", ocyc[0], 64'd6);
    // partial lane acceptance
    do_reset();
    drv(1, 0, 4'hf, 4'h0, 0);
    cyc_step();
    drv(0, 0, 0, 4'b0101, 0);
    #1 chk("partial_all", ov[0], 4'b1111);
    cyc_step();
    out_ready = 4'b1010;
    #1 chk("partial_rest", ov[0], 4'b1010);
    cyc_step();
    #1 chk("partial_done", ov[0], 4'h0);
    chk("partial_stall", ostall[0], 32'd1);
    // stall mode vs free-running time
    do_reset();
    drv(1, 2, 4'b0001, 4'h0, 0);
    cyc_step();
    drv(1, 4, 4'b0001, 4'h0, 0);
    cyc_step();
    drv(0, 0, 0, 4'h0, 0);
    repeat (5) cyc_step();
    out_ready = 4'hf;
    #1 chk("stall_held_cycle", ocyc[1], 64'd2);
    chk("stall_held_valid", ov[1], 4'b0001);
    chk("stall_count", ostall[1], 32'd5);
    chk("free_cycle", ocyc[0], 64'd7);
    cyc_step();
    #1 chk("free_second_due", ov[0], 4'b0001);
    chk("stall_second_wait", ov[1], 4'h0);
    chk("stall_cycle_after", ocyc[1], 64'd3);
    cyc_step();
    #1 chk("stall_second_due", ov[1], 4'b0001);
    chk("stall_second_cycle", ocyc[1], 64'd4);
    cyc_step();
    // full FIFO, then 20 entries across a pointer wrap
    do_reset();
    acc0 = 0;
    repeat (8) begin
      drv(1, 100, 4'($urandom_range(1, 15)), 4'hf, 0);
      cyc_step();
    end
    #1 chk("full_in_ready", rdy[0], 1'b0);
    for (int i = 0; i < 300 && acc0 < 20; i++) begin
      drv(1, 100, 4'($urandom_range(1, 15)), 4'hf, 0);
      cyc_step();
    end
    chk("wrap_accepted", 32'(acc0), 32'd20);
    drv(0, 0, 0, 4'hf, 0);
    repeat (12) cyc_step();
    #1 chk("wrap_drained", ov[0], 4'h0);
    // randomized traffic
    do_reset();
    repeat (400) begin
      drv(1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 64'd0 : m_cyc[0] + 64'($urandom_range(0, 6)),
          4'($urandom), 4'($urandom), 0);
      cyc_step();
    end
    // async reset with a partially served head and 3 entries queued
    do_reset();
    repeat (3) begin
      drv(1, 0, 4'hf, 4'h0, 0);
      cyc_step();
    end
    drv(0, 0, 0, 4'b0101, 0);
    cyc_step();
    do_reset();
    drv(0, 0, 0, 4'hf, 0);
    repeat (4) cyc_step();
    #1 chk("no_stale_valid", ov[0], 4'h0);
    // empty mask entry then finish
    do_reset();
    drv(1, 3, 4'h0, 4'hf, 0);
    cyc_step();
    drv(0, 0, 0, 4'hf, 1);
    repeat (2) cyc_step();
    #1 chk("empty_mask_valid", ov[0], 4'h0);
    chk("empty_mask_cycle", ocyc[0], 64'd3);
    cyc_step();
    #1 chk("finished_set", ofin[0], 1'b1);
    chk("finished_ready", rdy[0], 1'b0);
    chk("finished_cycle", ocyc[0], 64'd4);
    drv(1, 0, 4'hf, 4'hf, 1);
    repeat (3) cyc_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
